// File: rtl/l2c_req_responder_if.sv
// Request/answer types and the arbiter-facing bus of the L2 request responder.
// slave: the responder side; master: the arbiter side.

package l2c_req_responder_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int DEST_W = 4;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  typedef enum logic {
    ANS_READ_REPLY = 1'b0,
    ANS_WRITE_ACK  = 1'b1
  } ans_type_e;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    req_type_e         req_type;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] line;
  } l2arb_l2c_req_t;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    ans_type_e         ans_type;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] line;
  } l2c_l2arb_ans_t;

endpackage

interface l2c_req_responder_if;
  import l2c_req_responder_pkg::*;

  l2arb_l2c_req_t l2arb_l2c_req;
  logic           l2c_l2arb_req_rdy;
  l2c_l2arb_ans_t l2c_l2arb_ans;
  logic           l2arb_l2c_ans_rdy;

  modport slave (
    input  l2arb_l2c_req,
    input  l2arb_l2c_ans_rdy,
    output l2c_l2arb_req_rdy,
    output l2c_l2arb_ans
  );

  modport master (
    output l2arb_l2c_req,
    output l2arb_l2c_ans_rdy,
    input  l2c_l2arb_req_rdy,
    input  l2c_l2arb_ans
  );

endinterface

// File: rtl/l2c_req_responder.sv
// l2c_req_responder: single-outstanding L2 request responder with a fixed
// accept-to-answer latency and an internal line array (array "mem", never
// cleared, so it can be preloaded hierarchically).
// Optional feature macro L2C_RESP_WB_ACK_EN: when defined, writes answer with a
// write-ack; when undefined, writes are posted and return straight to IDLE.

module l2c_req_responder
  import l2c_req_responder_pkg::*;
#(
  parameter int N_LINES    = 256,
  parameter int LAT_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  l2c_req_responder_if.slave bus
);

  localparam int         IDX_W    = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam logic [7:0] LAT_LOAD = 8'(LAT_CYCLES - 1);

`ifdef L2C_RESP_WB_ACK_EN
  localparam bit WB_ACK = 1'b1;
`else
  localparam bit WB_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ANSWER
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rdy_q;

  logic [DEST_W-1:0] dest_q;
  req_type_e         type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;

  l2c_l2arb_ans_t    ans_q, ans_d;
  logic [LINE_W-1:0] mem [N_LINES];

  logic              accept;
  logic              expire;
  logic              commit;
  logic              enter_ans;

  logic [DEST_W-1:0] cur_dest;
  req_type_e         cur_type;
  logic [ADDR_W-1:0] cur_addr;
  logic [LINE_W-1:0] cur_line;
  logic [IDX_W-1:0]  cur_idx;

  // Current transaction fields: straight from the bus when LAT_CYCLES=1 finishes in the accept cycle, else the captured copy
  always_comb begin
    if (state_q == IDLE) begin
      cur_dest = bus.l2arb_l2c_req.dest;
      cur_type = bus.l2arb_l2c_req.req_type;
      cur_addr = bus.l2arb_l2c_req.line_addr;
      cur_line = bus.l2arb_l2c_req.line;
    end else begin
      cur_dest = dest_q;
      cur_type = type_q;
      cur_addr = addr_q;
      cur_line = line_q;
    end
  end

  assign cur_idx = (N_LINES > 1) ? cur_addr[IDX_W-1:0] : '0;

  // Next-state logic; flush overrides acceptance, expiry, commit and the answer handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    expire    = 1'b0;
    commit    = 1'b0;
    enter_ans = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.l2arb_l2c_req.valid && rdy_q) begin
          accept = 1'b1;
          if (LAT_CYCLES == 1) begin
            expire = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          expire = 1'b1;
        end
      end
      ANSWER: begin
        if (bus.l2arb_l2c_ans_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (expire) begin
      state_d = (cur_type == REQ_WRITE && !WB_ACK) ? IDLE : ANSWER;
      commit  = (cur_type == REQ_WRITE);
    end
    enter_ans = expire && (state_d == ANSWER);
    if (flush_i) begin
      state_d   = IDLE;
      cnt_d     = 8'd0;
      accept    = 1'b0;
      commit    = 1'b0;
      enter_ans = 1'b0;
    end
  end

  // Answer contents for the transaction that is finishing its latency
  always_comb begin
    ans_d           = '0;
    ans_d.valid     = 1'b1;
    ans_d.dest      = cur_dest;
    ans_d.line_addr = cur_addr;
    if (cur_type == REQ_WRITE) begin
      ans_d.ans_type = ANS_WRITE_ACK;
      ans_d.line     = cur_line;
    end else begin
      ans_d.ans_type = ANS_READ_REPLY;
      ans_d.line     = mem[cur_idx];
    end
  end

  // State, latency counter and the post-reset ready enable
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  // Capture the request fields on acceptance
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dest_q <= '0;
      type_q <= REQ_READ;
      addr_q <= '0;
      line_q <= '0;
    end else if (accept) begin
      dest_q <= bus.l2arb_l2c_req.dest;
      type_q <= bus.l2arb_l2c_req.req_type;
      addr_q <= bus.l2arb_l2c_req.line_addr;
      line_q <= bus.l2arb_l2c_req.line;
    end
  end

  // Answer register: loaded when ANSWER is entered, held while in it, zero elsewhere
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ans_q <= '0;
    end else if (enter_ans) begin
      ans_q <= ans_d;
    end else if (state_d != ANSWER) begin
      ans_q <= '0;
    end
  end

  // Line array write; no reset so contents survive reset and flush
  always_ff @(posedge clk_i) begin
    if (rst_n_i && commit) begin
      mem[cur_idx] <= cur_line;
    end
  end

  assign bus.l2c_l2arb_ans     = ans_q;
  assign bus.l2c_l2arb_req_rdy = rdy_q && (state_q == IDLE);

endmodule

// File: tb/tb_l2c_req_responder.sv
// Testbench for l2c_req_responder: a vector table run through a scoreboard on
// a LAT_CYCLES=4 instance, hand sequences for backpressure, flush and reset,
// and a LAT_CYCLES=1 / N_LINES=16 instance for the single-cycle and wrap corners.

module tb_l2c_req_responder;
  import l2c_req_responder_pkg::*;

  localparam int N_LINES = 256;
  localparam int LAT     = 4;
  localparam int N1      = 16;

`ifdef L2C_RESP_WB_ACK_EN
  localparam bit WB_ACK = 1'b1;
`else
  localparam bit WB_ACK = 1'b0;
`endif

  typedef struct {
    logic [DEST_W-1:0] dest;
    req_type_e         rtype;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
    bit                exp_ans;
    ans_type_e         exp_type;
    logic [LINE_W-1:0] exp_line;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_vec    = 0;
  int n_miss   = 0;
  int ans_seen = 0;
  l2c_l2arb_ans_t exp_q[$];

  l2c_req_responder_if bus();
  l2c_req_responder_if bus1();

  l2c_req_responder #(.N_LINES(N_LINES), .LAT_CYCLES(LAT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  l2c_req_responder #(.N_LINES(N1), .LAT_CYCLES(1)) dut1 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus1)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every answer handshake pops and compares one expected answer
  always @(negedge clk) begin
    if (rst_n && !flush && bus.l2c_l2arb_ans.valid && bus.l2arb_l2c_ans_rdy) begin
      ans_seen++;
      checkOutput("answer expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        checkOutput("answer fields", 256'(bus.l2c_l2arb_ans), 256'(exp_q.pop_front()));
      end
    end
  end

  task automatic driveReq(input logic [DEST_W-1:0] d, input req_type_e t, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] l, input bit push, input ans_type_e et,
                          input logic [LINE_W-1:0] el);
    int guard = 0;
    while (!bus.l2c_l2arb_req_rdy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("req_rdy before issue", 256'(bus.l2c_l2arb_req_rdy), 256'(1));
    bus.l2arb_l2c_req = '{valid: 1'b1, dest: d, req_type: t, line_addr: a, line: l};
    if (push) begin
      exp_q.push_back('{valid: 1'b1, dest: d, ans_type: et, line_addr: a, line: el});
    end
    @(posedge clk); #1;
    bus.l2arb_l2c_req.valid = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int guard = 0;
    while (!bus.l2c_l2arb_ans.valid && guard < LAT + 8) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput(name, 256'(bus.l2c_l2arb_ans.valid), 256'(1));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    driveReq(v.dest, v.rtype, v.addr, v.line, v.exp_ans, v.exp_type, v.exp_line);
    n = 1;
    if (v.exp_ans) begin
      while (!bus.l2c_l2arb_ans.valid && n < LAT + 8) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput({tag, " latency"}, 256'(n), 256'(LAT));
      @(posedge clk); #1;
      checkOutput({tag, " req_rdy after answer"}, 256'(bus.l2c_l2arb_req_rdy), 256'(1));
      checkOutput({tag, " scoreboard drained"}, 256'(exp_q.size()), 256'(0));
    end else begin
      while (!bus.l2c_l2arb_req_rdy && n < LAT + 8) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput({tag, " posted latency"}, 256'(n), 256'(LAT));
      checkOutput({tag, " posted no valid"}, 256'(bus.l2c_l2arb_ans.valid), 256'(0));
    end
  endtask

  // Runaway guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    vec_t           vecs[9];
    vec_t           rv;
    l2c_l2arb_ans_t exp1;
    int             seen0;

    bus.l2arb_l2c_req      = '0;
    bus.l2arb_l2c_ans_rdy  = 1'b1;
    bus1.l2arb_l2c_req     = '0;
    bus1.l2arb_l2c_ans_rdy = 1'b1;

    for (int i = 0; i < N_LINES; i++) begin
      dut.mem[i] = {16{8'(i)}};
    end
    dut.mem[5]  = {16{8'hA5}};
    dut1.mem[2] = {16{8'h22}};

    vecs[0] = '{dest: 4'h2, rtype: REQ_READ,  addr: 32'h5,   line: 128'h0, exp_ans: 1'b1,
                exp_type: ANS_READ_REPLY, exp_line: {16{8'hA5}}};
    vecs[1] = '{dest: 4'h1, rtype: REQ_WRITE, addr: 32'h3,   line: 128'h1234, exp_ans: WB_ACK,
                exp_type: ANS_WRITE_ACK, exp_line: 128'h1234};
    vecs[2] = '{dest: 4'h3, rtype: REQ_READ,  addr: 32'h3,   line: 128'h0, exp_ans: 1'b1,
                exp_type: ANS_READ_REPLY, exp_line: 128'h1234};
    vecs[3] = '{dest: 4'h4, rtype: REQ_READ,  addr: 32'h105, line: 128'h0, exp_ans: 1'b1,
                exp_type: ANS_READ_REPLY, exp_line: {16{8'hA5}}};
    vecs[4] = '{dest: 4'h5, rtype: REQ_WRITE, addr: 32'h2FF, line: 128'hDEADBEEF_00000000_CAFEF00D_11112222,
                exp_ans: WB_ACK, exp_type: ANS_WRITE_ACK, exp_line: 128'hDEADBEEF_00000000_CAFEF00D_11112222};
    vecs[5] = '{dest: 4'h6, rtype: REQ_READ,  addr: 32'hFF,  line: 128'h0, exp_ans: 1'b1,
                exp_type: ANS_READ_REPLY, exp_line: 128'hDEADBEEF_00000000_CAFEF00D_11112222};
    vecs[6] = '{dest: 4'h7, rtype: REQ_READ,  addr: 32'h7,   line: 128'h0, exp_ans: 1'b1,
                exp_type: ANS_READ_REPLY, exp_line: {16{8'h07}}};
    vecs[7] = '{dest: 4'hF, rtype: REQ_WRITE, addr: 32'h100, line: {128{1'b1}}, exp_ans: WB_ACK,
                exp_type: ANS_WRITE_ACK, exp_line: {128{1'b1}}};
    vecs[8] = '{dest: 4'h8, rtype: REQ_READ,  addr: 32'h300, line: 128'h0, exp_ans: 1'b1,
                exp_type: ANS_READ_REPLY, exp_line: {128{1'b1}}};

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_rdy", 256'(bus.l2c_l2arb_req_rdy), 256'(0));
    checkOutput("reset ans", 256'(bus.l2c_l2arb_ans), 256'(0));
    checkOutput("reset req_rdy lat1", 256'(bus1.l2c_l2arb_req_rdy), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("req_rdy after reset", 256'(bus.l2c_l2arb_req_rdy), 256'(1));
    checkOutput("req_rdy after reset lat1", 256'(bus1.l2c_l2arb_req_rdy), 256'(1));

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] backpressure");
    bus.l2arb_l2c_ans_rdy = 1'b0;
    seen0 = ans_seen;
    driveReq(4'hA, REQ_READ, 32'h5, 128'h0, 1'b1, ANS_READ_REPLY, {16{8'hA5}});
    waitValid("bp valid");
    exp1 = '{valid: 1'b1, dest: 4'hA, ans_type: ANS_READ_REPLY, line_addr: 32'h5, line: {16{8'hA5}}};
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("bp hold %0d", k), 256'(bus.l2c_l2arb_ans), 256'(exp1));
      checkOutput($sformatf("bp req_rdy low %0d", k), 256'(bus.l2c_l2arb_req_rdy), 256'(0));
      if (k == 5) bus.l2arb_l2c_ans_rdy = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("bp valid dropped", 256'(bus.l2c_l2arb_ans.valid), 256'(0));
    checkOutput("bp single answer", 256'(ans_seen - seen0), 256'(1));
    checkOutput("bp req_rdy back", 256'(bus.l2c_l2arb_req_rdy), 256'(1));

    $display("[TB] flush in WAIT");
    seen0 = ans_seen;
    driveReq(4'h3, REQ_WRITE, 32'h7, 128'hBAD0, 1'b0, ANS_WRITE_ACK, 128'h0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush wait req_rdy", 256'(bus.l2c_l2arb_req_rdy), 256'(1));
    checkOutput("flush wait no valid", 256'(bus.l2c_l2arb_ans.valid), 256'(0));
    repeat (LAT + 2) @(posedge clk);
    #1;
    checkOutput("flush wait no answer", 256'(ans_seen - seen0), 256'(0));
    rv = '{dest: 4'h2, rtype: REQ_READ, addr: 32'h7, line: 128'h0, exp_ans: 1'b1,
           exp_type: ANS_READ_REPLY, exp_line: {16{8'h07}}};
    applyStimulus(rv, "flush wait readback");

    $display("[TB] flush on commit edge");
    driveReq(4'h4, REQ_WRITE, 32'h9, 128'hBAD9, 1'b0, ANS_WRITE_ACK, 128'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush commit req_rdy", 256'(bus.l2c_l2arb_req_rdy), 256'(1));
    rv = '{dest: 4'h5, rtype: REQ_READ, addr: 32'h9, line: 128'h0, exp_ans: 1'b1,
           exp_type: ANS_READ_REPLY, exp_line: {16{8'h09}}};
    applyStimulus(rv, "flush commit readback");

    $display("[TB] flush in ANSWER");
    bus.l2arb_l2c_ans_rdy = 1'b0;
    seen0 = ans_seen;
    driveReq(4'h6, REQ_READ, 32'h5, 128'h0, 1'b0, ANS_READ_REPLY, 128'h0);
    waitValid("flush answer valid");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.l2arb_l2c_ans_rdy = 1'b1;
    checkOutput("flush answer dropped", 256'(bus.l2c_l2arb_ans.valid), 256'(0));
    checkOutput("flush answer req_rdy", 256'(bus.l2c_l2arb_req_rdy), 256'(1));

    $display("[TB] flush beats acceptance");
    bus.l2arb_l2c_req = '{valid: 1'b1, dest: 4'h7, req_type: REQ_READ, line_addr: 32'h5, line: 128'h0};
    flush = 1'b1;
    @(posedge clk); #1;
    bus.l2arb_l2c_req.valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush accept req_rdy", 256'(bus.l2c_l2arb_req_rdy), 256'(1));
    repeat (LAT + 2) @(posedge clk);
    #1;
    checkOutput("flush no answers", 256'(ans_seen - seen0), 256'(0));

    $display("[TB] reset in ANSWER");
    bus.l2arb_l2c_ans_rdy = 1'b0;
    seen0 = ans_seen;
    driveReq(4'h9, REQ_READ, 32'h5, 128'h0, 1'b0, ANS_READ_REPLY, 128'h0);
    waitValid("rst answer valid");
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst answer cleared", 256'(bus.l2c_l2arb_ans), 256'(0));
    checkOutput("rst req_rdy low", 256'(bus.l2c_l2arb_req_rdy), 256'(0));
    @(posedge clk); #1;
    checkOutput("rst req_rdy still low", 256'(bus.l2c_l2arb_req_rdy), 256'(0));
    rst_n = 1'b1;
    bus.l2arb_l2c_ans_rdy = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst release req_rdy", 256'(bus.l2c_l2arb_req_rdy), 256'(1));
    checkOutput("rst no answer", 256'(ans_seen - seen0), 256'(0));

    $display("[TB] reset mid-write");
    driveReq(4'hB, REQ_WRITE, 32'hB, 128'hBADB, 1'b0, ANS_WRITE_ACK, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rv = '{dest: 4'hC, rtype: REQ_READ, addr: 32'hB, line: 128'h0, exp_ans: 1'b1,
           exp_type: ANS_READ_REPLY, exp_line: {16{8'h0B}}};
    applyStimulus(rv, "rst write readback");

    $display("[TB] single-cycle latency instance");
    checkOutput("lat1 req_rdy", 256'(bus1.l2c_l2arb_req_rdy), 256'(1));
    bus1.l2arb_l2c_req = '{valid: 1'b1, dest: 4'h3, req_type: REQ_READ, line_addr: 32'h12, line: 128'h0};
    @(posedge clk); #1;
    bus1.l2arb_l2c_req.valid = 1'b0;
    exp1 = '{valid: 1'b1, dest: 4'h3, ans_type: ANS_READ_REPLY, line_addr: 32'h12, line: {16{8'h22}}};
    checkOutput("lat1 read answer", 256'(bus1.l2c_l2arb_ans), 256'(exp1));
    @(posedge clk); #1;
    checkOutput("lat1 req_rdy after answer", 256'(bus1.l2c_l2arb_req_rdy), 256'(1));
    checkOutput("lat1 valid dropped", 256'(bus1.l2c_l2arb_ans.valid), 256'(0));
    bus1.l2arb_l2c_req = '{valid: 1'b1, dest: 4'h4, req_type: REQ_WRITE, line_addr: 32'h24, line: 128'h44};
    @(posedge clk); #1;
    bus1.l2arb_l2c_req.valid = 1'b0;
`ifdef L2C_RESP_WB_ACK_EN
    exp1 = '{valid: 1'b1, dest: 4'h4, ans_type: ANS_WRITE_ACK, line_addr: 32'h24, line: 128'h44};
    checkOutput("lat1 write ack", 256'(bus1.l2c_l2arb_ans), 256'(exp1));
    @(posedge clk); #1;
`else
    checkOutput("lat1 posted no valid", 256'(bus1.l2c_l2arb_ans.valid), 256'(0));
`endif
    checkOutput("lat1 req_rdy after write", 256'(bus1.l2c_l2arb_req_rdy), 256'(1));
    bus1.l2arb_l2c_req = '{valid: 1'b1, dest: 4'h5, req_type: REQ_READ, line_addr: 32'h4, line: 128'h0};
    @(posedge clk); #1;
    bus1.l2arb_l2c_req.valid = 1'b0;
    exp1 = '{valid: 1'b1, dest: 4'h5, ans_type: ANS_READ_REPLY, line_addr: 32'h4, line: 128'h44};
    checkOutput("lat1 write readback", 256'(bus1.l2c_l2arb_ans), 256'(exp1));
    @(posedge clk); #1;

    checkOutput("final scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
